// File: rtl/lcd_bus_if.sv
// Avalon-MM slave bundle between the interconnect and the LCD bus sequencer.
interface lcd_bus_if;
    logic [1:0] address;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that sequences an HD44780-style LCD bus with programmable
// setup / E-high / hold timing and optional busy-flag polling after writes.
module lcd_bus_sequencer #(
    parameter int SETUP_CYC  = 4,
    parameter int E_HIGH_CYC = 12,
    parameter int HOLD_CYC   = 4,
    parameter int BUSY_POLL  = 1,
    parameter int MAX_POLLS  = 1023,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    lcd_bus_if.slave   bus,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_in,
    output logic       timeout_err
);
    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EHIGH = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [PCW-1:0]   LAST_POLL = PCW'(MAX_POLLS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_EHIGH  = 3'd2,
        S_HOLD   = 3'd3,
        S_PSETUP = 3'd4,
        S_PEHIGH = 3'd5,
        S_PHOLD  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [1:0]       r_addr, w_next_addr;
    logic [7:0]       r_wdata, w_next_wdata;
    logic             r_is_wr, w_next_is_wr;
    logic [PCW-1:0]   r_polls;
    logic             r_db7;
    logic             r_timeout;
    logic             r_lcd_e, r_lcd_rs, r_lcd_rw, r_oe, r_waitreq;
    logic [7:0]       r_dout, r_readdata;

    logic w_accept, w_poll_inc, w_set_timeout;
    logic w_cnt_zero, w_illegal, w_next_xfer, w_next_poll;

    assign w_cnt_zero  = (r_cnt == {CNT_W{1'b0}});
    assign w_illegal   = bus.write ? bus.address[0] : ~bus.address[0];
    assign w_next_xfer = (w_next_state == S_SETUP) || (w_next_state == S_EHIGH) ||
                         (w_next_state == S_HOLD);
    assign w_next_poll = (w_next_state == S_PSETUP) || (w_next_state == S_PEHIGH) ||
                         (w_next_state == S_PHOLD);

    // Next-state, phase counter and request latching.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_addr   = r_addr;
        w_next_wdata  = r_wdata;
        w_next_is_wr  = r_is_wr;
        w_accept      = 1'b0;
        w_poll_inc    = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.write || bus.read) begin
                    w_accept     = 1'b1;
                    w_next_addr  = bus.address;
                    w_next_wdata = bus.writedata;
                    w_next_is_wr = bus.write;
                    if (w_illegal) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_SETUP;
                        w_next_cnt   = LD_SETUP;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SETUP: begin
                if (!w_cnt_zero) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_next_state = S_EHIGH;
                    w_next_cnt   = LD_EHIGH;
                end
            end
            S_EHIGH: begin
                if (!w_cnt_zero) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_next_state = S_HOLD;
                    w_next_cnt   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_cnt_zero) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else if ((BUSY_POLL != 0) && r_is_wr) begin
                    w_next_state = S_PSETUP;
                    w_next_cnt   = LD_SETUP;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_PSETUP: begin
                if (!w_cnt_zero) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_next_state = S_PEHIGH;
                    w_next_cnt   = LD_EHIGH;
                end
            end
            S_PEHIGH: begin
                if (!w_cnt_zero) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_next_state = S_PHOLD;
                    w_next_cnt   = LD_HOLD;
                end
            end
            S_PHOLD: begin
                if (!w_cnt_zero) begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else if (r_db7) begin
                    // Busy poll finished; give up once MAX_POLLS busy reads are seen.
                    if (r_polls == LAST_POLL) begin
                        w_set_timeout = 1'b1;
                        w_next_state  = S_DONE;
                    end else begin
                        w_poll_inc   = 1'b1;
                        w_next_state = S_PSETUP;
                        w_next_cnt   = LD_SETUP;
                    end
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered pin/bus outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_addr     <= 2'b00;
            r_wdata    <= 8'h00;
            r_is_wr    <= 1'b0;
            r_polls    <= {PCW{1'b0}};
            r_db7      <= 1'b0;
            r_timeout  <= 1'b0;
            r_readdata <= 8'h00;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_oe       <= 1'b0;
            r_dout     <= 8'h00;
            r_waitreq  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_addr  <= w_next_addr;
            r_wdata <= w_next_wdata;
            r_is_wr <= w_next_is_wr;

            if (w_accept) begin
                r_polls <= {PCW{1'b0}};
            end else if (w_poll_inc) begin
                r_polls <= r_polls + PCW'(1);
            end else begin
                r_polls <= r_polls;
            end

            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end

            if ((r_state == S_PEHIGH) && w_cnt_zero) begin
                r_db7 <= lcd_data_in[7];
            end else begin
                r_db7 <= r_db7;
            end

            if (w_accept) begin
                r_readdata <= 8'h00;
            end else if ((r_state == S_EHIGH) && w_cnt_zero && !r_is_wr) begin
                r_readdata <= lcd_data_in;
            end else begin
                r_readdata <= r_readdata;
            end

            r_lcd_e   <= (w_next_state == S_EHIGH) || (w_next_state == S_PEHIGH);
            r_lcd_rs  <= w_next_xfer ? w_next_addr[1] : 1'b0;
            r_lcd_rw  <= w_next_xfer ? w_next_addr[0] : w_next_poll;
            r_oe      <= w_next_xfer && w_next_is_wr;
            r_dout    <= (w_next_xfer && w_next_is_wr) ? w_next_wdata : 8'h00;
            r_waitreq <= (w_next_state != S_DONE);
        end
    end

    assign LCD_E           = r_lcd_e;
    assign LCD_RS          = r_lcd_rs;
    assign LCD_RW          = r_lcd_rw;
    assign lcd_data_oe     = r_oe;
    assign lcd_data_out    = r_dout;
    assign timeout_err     = r_timeout;
    assign bus.readdata    = r_readdata;
    assign bus.waitrequest = r_waitreq;
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench: two sequencer instances (no polling / polling with MAX_POLLS=3)
// driven by directed and random Avalon requests against a transaction-level model.
module tb_lcd_bus_sequencer;
    localparam int S  = 4;
    localparam int EH = 12;
    localparam int H  = 4;
    localparam int T  = S + EH + H;
    localparam int N_DIR = 8;
    localparam int N_TXN = 34;

    typedef struct {
        int         id;
        int         issue;
        int         lat;
        int         polls;
        bit         legal;
        bit         wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         tmo;
    } exp_t;

    localparam logic [1:0] DA  [0:7] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2};
    localparam bit         DW  [0:7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam bit         DR  [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [7:0] DD  [0:7] = '{8'h41, 8'h00, 8'h38, 8'h01, 8'hAA, 8'h00, 8'h55, 8'h48};
    localparam logic [7:0] DRB [0:7] = '{8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h77, 8'h33, 8'h00};
    localparam int         DB  [0:7] = '{0, 0, 2, 5, 0, 0, 1, 0};

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, req);
    endtask

    // Transaction-level expectation straight from the bus rules.
    function automatic exp_t model(input int bp, input int maxp, input int id, input int issue,
                                   input logic [1:0] a, input bit w, input logic [7:0] d,
                                   input logic [7:0] rb, input int busy);
        exp_t x;
        x.id = id; x.issue = issue; x.addr = a; x.wr = w; x.wdata = d;
        x.legal = w ? !a[0] : a[0];
        x.polls = 0; x.tmo = 1'b0;
        if (x.legal && w && bp != 0) begin
            if (busy >= maxp) begin x.polls = maxp; x.tmo = 1'b1; end
            else x.polls = busy + 1;
        end
        x.lat   = x.legal ? (T + 1) + x.polls * T : 1;
        x.rdata = (!w && x.legal) ? rb : 8'h00;
        return x;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int P_BP = (g == 0) ? 0 : 1;
        localparam int P_MP = (g == 0) ? 1023 : 3;

        lcd_bus_if bif ();
        logic       rst;
        logic       e, rs, rw, oe, tmo;
        logic [7:0] dout;
        logic [7:0] din = 8'h00;
        bit         done = 1'b0;
        exp_t       q[$];
        exp_t       x;
        int         k;
        int         pin_err = 0;
        int         epulses = 0;
        bit         e_prev = 1'b0;
        bit         cur_wr = 1'b0;
        int         cur_busy = 0;
        logic [7:0] cur_rd = 8'h00;

        lcd_bus_sequencer #(
            .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
            .BUSY_POLL(P_BP), .MAX_POLLS(P_MP), .CNT_W(8)
        ) u_dut (
            .clk(clk), .reset(rst), .bus(bif),
            .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw),
            .lcd_data_out(dout), .lcd_data_oe(oe), .lcd_data_in(din),
            .timeout_err(tmo)
        );

        // LCD model: data byte for reads, busy flag for the first cur_busy polls.
        always @(negedge clk) begin
            if (e && !e_prev) epulses = epulses + 1;
            e_prev = e;
            if (e) begin
                if (cur_wr) din = {((epulses - 1) >= 1) && ((epulses - 1) <= cur_busy), 7'($urandom)};
                else din = cur_rd;
            end else begin
                din = 8'($urandom);
            end
        end

        // Monitor: per-cycle pin waveform and completion checks against the queue head.
        always @(negedge clk) begin
            if (q.size() == 0) begin
                if (!bif.waitrequest) check($sformatf("u%0d spurious_done", g), 0, 1);
            end else begin
                x = q[0];
                k = cyc - x.issue;
                if (k >= 1) begin
                    if (!bif.waitrequest) begin
                        void'(q.pop_front());
                        check($sformatf("u%0d t%0d latency", g, x.id), k, x.lat);
                        if (!x.wr) check($sformatf("u%0d t%0d readdata", g, x.id), int'(bif.readdata), int'(x.rdata));
                        check($sformatf("u%0d t%0d timeout_err", g, x.id), int'(tmo), int'(x.tmo));
                        check($sformatf("u%0d t%0d e_pulses", g, x.id), epulses, x.legal ? 1 + x.polls : 0);
                        check($sformatf("u%0d t%0d pin_errors", g, x.id), pin_err, 0);
                        pin_err = 0;
                    end else if (k > x.lat + 100) begin
                        void'(q.pop_front());
                        check($sformatf("u%0d t%0d no_completion", g, x.id), k, x.lat);
                        pin_err = 0;
                    end else begin
                        bit ers, erw, eoe, ee;
                        int j;
                        if (k <= T) begin
                            ers = x.addr[1]; erw = x.addr[0]; eoe = x.wr; j = k;
                        end else begin
                            ers = 1'b0; erw = 1'b1; eoe = 1'b0; j = (k - T - 1) % T + 1;
                        end
                        ee = (j > S) && (j <= S + EH);
                        if (rs !== ers || rw !== erw || oe !== eoe || e !== ee ||
                            (eoe && dout !== x.wdata) || tmo !== 1'b0)
                            pin_err++;
                    end
                end
            end
        end

        // Stimulus: directed table, mid-strobe reset, then random requests.
        initial begin
            logic [1:0] a;
            bit         w, r, ok;
            logic [7:0] d, rb;
            int         busy, idle, kind;
            rst = 1'b1;
            bif.address = 2'd0; bif.read = 1'b0; bif.write = 1'b0; bif.writedata = 8'h00;
            repeat (3) @(negedge clk);
            check($sformatf("u%0d rst_waitrequest", g), int'(bif.waitrequest), 1);
            check($sformatf("u%0d rst_pins", g), int'({e, rs, rw, oe, tmo}), 0);
            check($sformatf("u%0d rst_data", g), int'({dout, bif.readdata}), 0);
            rst = 1'b0;
            for (int i = 0; i < N_TXN; i++) begin
                if (i < N_DIR) begin
                    a = DA[i]; w = DW[i]; r = DR[i]; d = DD[i]; rb = DRB[i]; busy = DB[i]; idle = 0;
                end else begin
                    a = 2'($urandom_range(0, 3));
                    kind = $urandom_range(0, 2);
                    w = (kind != 1); r = (kind != 0);
                    d = 8'($urandom); rb = 8'($urandom);
                    busy = $urandom_range(0, 4); idle = $urandom_range(0, 2);
                end
                if (i == N_DIR - 1) begin
                    cur_wr = 1'b1; cur_busy = 0; epulses = 0;
                    bif.address = 2'd2; bif.write = 1'b1; bif.writedata = 8'hC3;
                    repeat (8) @(negedge clk);
                    check($sformatf("u%0d mid_ehigh_e", g), int'(e), 1);
                    rst = 1'b1; bif.write = 1'b0;
                    @(negedge clk);
                    check($sformatf("u%0d post_rst_e_oe", g), int'({e, oe}), 0);
                    check($sformatf("u%0d post_rst_waitrequest", g), int'(bif.waitrequest), 1);
                    rst = 1'b0;
                end
                cur_wr = w; cur_busy = busy; cur_rd = rb; epulses = 0;
                q.push_back(model(P_BP, P_MP, i, cyc, a, w, d, rb, busy));
                bif.address = a; bif.write = w; bif.read = r; bif.writedata = d;
                ok = 1'b0;
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk);
                    if (!bif.waitrequest) begin ok = 1'b1; break; end
                end
                if (!ok) check($sformatf("u%0d t%0d drv_bound", g, i), 0, 1);
                @(negedge clk);
                bif.read = 1'b0; bif.write = 1'b0;
                repeat (idle) @(negedge clk);
            end
            repeat (4) @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 60000; t++) begin
            @(posedge clk);
            if (g_u[0].done && g_u[1].done) break;
        end
        if (!(g_u[0].done && g_u[1].done)) check("global_bound", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
